// File: rtl/buffer_ra_serializer.sv
// buffer_ra_serializer
//   Transmit-side word-to-chunk serializer. Accepts BUFFER_SIZE-bit words over
//   a valid/ready handshake and emits them as OUTPUT_SIZE-bit chunks, one chunk
//   per trigger strobe. Chunk order mirrors the dibit receive buffer's REVERSE
//   convention, so both blocks with equal parameters form an identity loop.
//   A one-word holding register allows gapless back-to-back words.
//
// Ports:
//   clk_in     in   system clock (rising edge)
//   rst_in     in   asynchronous active-low reset
//   data_in    in   word to transmit
//   valid_in   in   data_in is valid
//   ready_out  out  a word can be accepted (holding register empty)
//   trigger    in   advance strobe; consumer samples data_out when trigger=1
//   data_out   out  current chunk, 0 when idle
//   valid_out  out  data_out carries word data
//   last_out   out  data_out is the final chunk of the word
module buffer_ra_serializer #(
    parameter int unsigned BUFFER_SIZE = 8,
    parameter int unsigned OUTPUT_SIZE = 2,
    parameter bit          REVERSE     = 1'b0
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [BUFFER_SIZE-1:0] data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic                   trigger,
    output logic [OUTPUT_SIZE-1:0] data_out,
    output logic                   valid_out,
    output logic                   last_out
);

    localparam int unsigned CHUNKS   = BUFFER_SIZE / OUTPUT_SIZE;
    localparam int unsigned CW       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CHUNKS - 1);

    generate
        if ((BUFFER_SIZE % OUTPUT_SIZE) != 0) begin : g_bad_size
            $error("buffer_ra_serializer: BUFFER_SIZE must be a multiple of OUTPUT_SIZE");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 r_state, w_state;
    logic [BUFFER_SIZE-1:0] r_sr, w_sr;
    logic [BUFFER_SIZE-1:0] r_hold, w_hold;
    logic                   r_hold_valid, w_hold_valid;
    logic [CW-1:0]          r_cnt, w_cnt;

    logic w_accept;
    logic w_active;
    logic w_last;

    assign ready_out = ~r_hold_valid;
    assign w_accept  = valid_in & ready_out;
    assign w_active  = (r_state == SHIFT);
    assign w_last    = (r_cnt == LAST_CNT);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= IDLE;
            r_sr         <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state;
            r_sr         <= w_sr;
            r_hold       <= w_hold;
            r_hold_valid <= w_hold_valid;
            r_cnt        <= w_cnt;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_sr         = r_sr;
        w_hold       = r_hold;
        w_hold_valid = r_hold_valid;
        w_cnt        = r_cnt;

        case (r_state)
            IDLE: begin
                // Holding register is bypassed; trigger has no effect here.
                if (w_accept) begin
                    w_sr    = data_in;
                    w_cnt   = '0;
                    w_state = SHIFT;
                end
            end
            SHIFT: begin
                if (trigger && w_last) begin
                    // Last chunk consumed: reload from hold first, else take a
                    // word offered this cycle directly, else go idle. ready_out
                    // is low whenever hold is valid, so the first two cannot
                    // collide.
                    if (r_hold_valid) begin
                        w_sr         = r_hold;
                        w_hold_valid = 1'b0;
                        w_cnt        = '0;
                    end else if (w_accept) begin
                        w_sr  = data_in;
                        w_cnt = '0;
                    end else begin
                        w_state = IDLE;
                    end
                end else begin
                    if (trigger) begin
                        w_sr  = REVERSE ? (r_sr >> OUTPUT_SIZE) : (r_sr << OUTPUT_SIZE);
                        w_cnt = r_cnt + 1'b1;
                    end
                    if (w_accept) begin
                        w_hold       = data_in;
                        w_hold_valid = 1'b1;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_comb begin
        data_out = '0;
        if (w_active) begin
            data_out = REVERSE ? r_sr[OUTPUT_SIZE-1:0] : r_sr[BUFFER_SIZE-1 -: OUTPUT_SIZE];
        end
    end

    assign valid_out = w_active;
    assign last_out  = w_active & w_last;

endmodule

// File: tb/tb_buffer_ra_serializer.sv
module tb_buffer_ra_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       trigger;

    logic       ready0, valid0, last0;
    logic [1:0] data0;
    logic       ready1, valid1, last1;
    logic [1:0] data1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    buffer_ra_serializer #(.BUFFER_SIZE(8), .OUTPUT_SIZE(2), .REVERSE(1'b0)) dut0 (
        .clk_in(clk), .rst_in(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready0), .trigger(trigger), .data_out(data0),
        .valid_out(valid0), .last_out(last0)
    );

    buffer_ra_serializer #(.BUFFER_SIZE(8), .OUTPUT_SIZE(2), .REVERSE(1'b1)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready1), .trigger(trigger), .data_out(data1),
        .valid_out(valid1), .last_out(last1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    logic [1:0] ord0 [4];
    logic [1:0] ord1 [4];
    logic [1:0] b2b  [8];
    logic       b2b_rdy [8];
    logic [1:0] rst_seq [4];
    logic [1:0] sp_exp [12];
    logic [7:0] sp_words [3];
    logic [7:0] lb_bytes [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         widx, nch, stalls;
        logic       acc, prev_trig, prev_v;
        logic [1:0] prev_d;
        logic [7:0] rx0, rx1;

        ord0    = '{2'b01, 2'b10, 2'b11, 2'b11};
        ord1    = '{2'b11, 2'b11, 2'b10, 2'b01};
        b2b     = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b01};
        b2b_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst_seq = '{2'b00, 2'b01, 2'b10, 2'b11};
        sp_words = '{8'h12, 8'h34, 8'h56};
        sp_exp  = '{2'b00, 2'b01, 2'b00, 2'b10,
                    2'b00, 2'b11, 2'b01, 2'b00,
                    2'b01, 2'b01, 2'b01, 2'b10};
        lb_bytes = '{8'h5A, 8'hA5, 8'hFF, 8'h00};

        // Reset held for two cycles
        rst_n = 1'b0; data_in = '0; valid_in = 1'b0; trigger = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready0", ready0, 1);
        chk("rst_data0",  data0, 0);
        chk("rst_valid0", valid0, 0);
        chk("rst_last0",  last0, 0);
        chk("rst_ready1", ready1, 1);
        chk("rst_data1",  data1, 0);
        rst_n = 1'b1;

        // Trigger while idle leaves outputs at zero
        trigger = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_data0",  data0, 0);
            chk("idle_valid0", valid0, 0);
            chk("idle_last0",  last0, 0);
        end
        trigger = 1'b0;

        // Chunk order, 0x6F, trigger every cycle, both REVERSE values
        data_in = 8'h6F; valid_in = 1'b1; trigger = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("order_data0",  data0, ord0[i]);
            chk("order_data1",  data1, ord1[i]);
            chk("order_valid0", valid0, 1);
            chk("order_last0",  last0, (i == 3));
            chk("order_last1",  last1, (i == 3));
            @(negedge clk);
        end
        chk("order_end_valid0", valid0, 0);
        chk("order_end_data0",  data0, 0);
        chk("order_end_valid1", valid1, 0);
        trigger = 1'b0;

        // Back-to-back 0xB0 then 0xC5
        data_in = 8'hB0; valid_in = 1'b1; trigger = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_data0",  data0, b2b[i]);
            chk("b2b_ready0", ready0, b2b_rdy[i]);
            chk("b2b_valid0", valid0, 1);
            chk("b2b_last0",  last0, (i == 3 || i == 7));
            if (i == 0) data_in = 8'hC5;
            if (i == 1) valid_in = 1'b0;
            @(negedge clk);
        end
        chk("b2b_end_valid0", valid0, 0);
        chk("b2b_end_ready0", ready0, 1);
        trigger = 1'b0;

        // Sparse trigger, three words offered back to back
        widx = 0; nch = 0; stalls = 0;
        data_in = sp_words[0]; valid_in = 1'b1; trigger = 1'b0;
        for (int c = 0; c < 80; c++) begin
            acc       = valid_in & ready0;
            prev_trig = trigger;
            prev_v    = valid0;
            prev_d    = data0;
            @(negedge clk);
            if (acc) begin
                widx++;
                if (widx < 3) data_in = sp_words[widx];
                else valid_in = 1'b0;
            end
            if (valid_in && !ready0) stalls++;
            if (prev_v && !prev_trig) begin
                chk("sparse_stable_data0",  data0, prev_d);
                chk("sparse_stable_valid0", valid0, 1);
            end
            trigger = ((c % 4) == 3);
            if (trigger && valid0) begin
                if (nch < 12) chk("sparse_chunk0", data0, sp_exp[nch]);
                nch++;
            end
        end
        trigger = 1'b0;
        chk("sparse_chunk_count", nch, 12);
        chk("sparse_words_taken", widx, 3);
        chk("sparse_stalled", (stalls != 0), 1);
        chk("sparse_end_valid0", valid0, 0);
        chk("sparse_end_ready0", ready0, 1);

        // Asynchronous reset in the middle of a word
        data_in = 8'h6F; valid_in = 1'b1; trigger = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_pre_data0", data0, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data0",  data0, 0);
        chk("arst_valid0", valid0, 0);
        chk("arst_last0",  last0, 0);
        chk("arst_ready0", ready0, 1);
        chk("arst_data1",  data1, 0);
        trigger = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_rel_valid0", valid0, 0);
        data_in = 8'h1B; valid_in = 1'b1; trigger = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("arst_word_data0", data0, rst_seq[i]);
            chk("arst_word_last0", last0, (i == 3));
            @(negedge clk);
        end
        chk("arst_word_end_valid0", valid0, 0);
        trigger = 1'b0;

        // Loopback into a behavioural receive buffer, both REVERSE values
        for (int b = 0; b < 4; b++) begin
            data_in = lb_bytes[b]; valid_in = 1'b1; trigger = 1'b1;
            @(negedge clk);
            valid_in = 1'b0;
            rx0 = '0; rx1 = '0;
            for (int k = 0; k < 4; k++) begin
                rx0 = {rx0[5:0], data0};
                rx1 = {data1, rx1[7:2]};
                @(negedge clk);
            end
            chk("loop_rx_rev0", rx0, lb_bytes[b]);
            chk("loop_rx_rev1", rx1, lb_bytes[b]);
            chk("loop_end_valid0", valid0, 0);
        end
        trigger = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
